// File: rtl/decode_redirect_unit.sv
// decode_redirect_unit: IF/ID register with decode-stage beq/bne/j/jal resolution, wrong-path squash and taken-redirect counter
module decode_redirect_unit #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      InstrF,
  input  logic [31:0]      PCPlus4F,
  input  logic             StallD,
  input  logic [31:0]      RD1D,
  input  logic [31:0]      RD2D,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [1:0]       PCSrcD,
  output logic [31:0]      PCBranchD,
  output logic [31:0]      PCJumpD,
  output logic [CNT_W-1:0] TakenCount
);
  logic [31:0]      instr_q, instr_d, pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op;
  logic [15:0]      imm;
  logic             en, eq, br_taken, jump;
  assign op  = instr_q[31:26];
  assign imm = instr_q[15:0];
  assign en  = valid_q & ~StallD;
  assign eq  = RD1D == RD2D;
  // Bubbles carry valid_q=0, so a bubble can never redirect whatever NOP_INSTR decodes to
  assign br_taken = en & (((op == 6'b000100) & eq) | ((op == 6'b000101) & ~eq));
  assign jump     = en & ((op == 6'b000010) | (op == 6'b000011));
  assign PCSrcD    = jump ? 2'b10 : br_taken ? 2'b01 : 2'b00;
  assign PCBranchD = pc4_q + {{14{imm[15]}}, imm, 2'b00};
  assign PCJumpD   = {pc4_q[31:28], instr_q[25:0], 2'b00};
  assign InstrD     = instr_q;
  assign PCPlus4D   = pc4_q;
  assign ValidD     = valid_q;
  assign TakenCount = cnt_q;
  always_comb begin
    instr_d = StallD ? instr_q : (PCSrcD != 2'b00) ? NOP_INSTR : InstrF;
    pc4_d   = StallD ? pc4_q : PCPlus4F;
    valid_d = StallD ? valid_q : (PCSrcD == 2'b00);
    cnt_d   = ((PCSrcD != 2'b00) && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_decode_redirect_unit.sv
// tb_decode_redirect_unit: directed checks of redirect resolution, squash, stall and counter saturation
module tb_decode_redirect_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] InstrF = '0, PCPlus4F = '0, RD1D = '0, RD2D = '0;
  logic        StallD = 1'b0;
  logic [31:0] InstrD, PCPlus4D, PCBranchD, PCJumpD;
  logic        ValidD;
  logic [1:0]  PCSrcD;
  logic [3:0]  TakenCount;
  int errors = 0;
  int checks = 0;

  decode_redirect_unit #(.CNT_W(4), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .StallD(StallD),
    .RD1D(RD1D), .RD2D(RD2D), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .PCJumpD(PCJumpD), .TakenCount(TakenCount)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    InstrF = 32'h2001_0001; PCPlus4F = 32'h0000_0044;
    #2 rst_n = 1'b1;
    tick();
    tick();
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL reset_pre_valid got=%0b exp=1", ValidD); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=00000000", InstrD); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ValidD); end
    checks++; if (PCSrcD !== 2'b00) begin errors++; $display("FAIL reset_pcsrc got=%b exp=00", PCSrcD); end
    checks++; if (TakenCount !== 4'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", TakenCount); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=00000000", PCPlus4D); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_beq_taken;
    InstrF = 32'h1000_0003; PCPlus4F = 32'h0000_0104; RD1D = 32'd5; RD2D = 32'd5;
    tick();
    checks++; if (PCSrcD !== 2'b01) begin errors++; $display("FAIL beq_pcsrc got=%b exp=01", PCSrcD); end
    checks++; if (PCBranchD !== 32'h0000_0110) begin errors++; $display("FAIL beq_target got=%h exp=00000110", PCBranchD); end
    InstrF = 32'h2001_0001; PCPlus4F = 32'h0000_0108;
    tick();
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL beq_squash_valid got=%0b exp=0", ValidD); end
    checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL beq_squash_instr got=%h exp=00000000", InstrD); end
    checks++; if (PCSrcD !== 2'b00) begin errors++; $display("FAIL beq_bubble_pcsrc got=%b exp=00", PCSrcD); end
    checks++; if (TakenCount !== 4'h1) begin errors++; $display("FAIL beq_count got=%h exp=1", TakenCount); end
  endtask

  task automatic test_bne_wrap;
    InstrF = 32'h1400_0002; PCPlus4F = 32'h0000_0200; RD1D = 32'd7; RD2D = 32'd7;
    tick();
    checks++; if (PCSrcD !== 2'b00) begin errors++; $display("FAIL bne_nt_pcsrc got=%b exp=00", PCSrcD); end
    InstrF = 32'h2002_0005; PCPlus4F = 32'h0000_0204;
    tick();
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL bne_next_valid got=%0b exp=1", ValidD); end
    checks++; if (InstrD !== 32'h2002_0005) begin errors++; $display("FAIL bne_next_instr got=%h exp=20020005", InstrD); end
    RD2D = 32'd8;
    #1;
    checks++; if (PCSrcD !== 2'b00) begin errors++; $display("FAIL nonctl_pcsrc got=%b exp=00", PCSrcD); end
    RD2D = 32'd7;
    InstrF = 32'h1000_FFFF; PCPlus4F = 32'h0000_0000;
    tick();
    checks++; if (PCBranchD !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got=%h exp=fffffffc", PCBranchD); end
    checks++; if (PCSrcD !== 2'b01) begin errors++; $display("FAIL wrap_pcsrc got=%b exp=01", PCSrcD); end
    InstrF = 32'h2003_0003; PCPlus4F = 32'h0000_0004;
    tick();
    checks++; if (TakenCount !== 4'h2) begin errors++; $display("FAIL wrap_count got=%h exp=2", TakenCount); end
  endtask

  task automatic test_jal;
    InstrF = 32'h0C00_0040; PCPlus4F = 32'hA000_0010;
    tick();
    checks++; if (PCSrcD !== 2'b10) begin errors++; $display("FAIL jal_pcsrc got=%b exp=10", PCSrcD); end
    checks++; if (PCJumpD !== 32'hA000_0100) begin errors++; $display("FAIL jal_target got=%h exp=a0000100", PCJumpD); end
    InstrF = 32'h0800_0008; PCPlus4F = 32'hA000_0014;
    tick();
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin errors++; $display("FAIL jal_squash got valid=%0b instr=%h exp valid=0 instr=00000000", ValidD, InstrD); end
    checks++; if (PCSrcD !== 2'b00) begin errors++; $display("FAIL jal_b2b_pcsrc got=%b exp=00", PCSrcD); end
    checks++; if (TakenCount !== 4'h3) begin errors++; $display("FAIL jal_count got=%h exp=3", TakenCount); end
  endtask

  task automatic test_stall;
    InstrF = 32'h1000_0004; PCPlus4F = 32'h0000_0300; RD1D = 32'd1; RD2D = 32'd1;
    tick();
    StallD = 1'b1;
    InstrF = 32'h2004_0004; PCPlus4F = 32'h0000_0304;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (PCSrcD !== 2'b00) begin errors++; $display("FAIL stall_pcsrc cyc=%0d got=%b exp=00", i, PCSrcD); end
      checks++; if (InstrD !== 32'h1000_0004 || PCPlus4D !== 32'h0000_0300) begin errors++; $display("FAIL stall_hold cyc=%0d got instr=%h pc4=%h exp instr=10000004 pc4=00000300", i, InstrD, PCPlus4D); end
      if (i < 2) tick();
    end
    checks++; if (TakenCount !== 4'h3) begin errors++; $display("FAIL stall_count got=%h exp=3", TakenCount); end
    RD2D = 32'd2;
    StallD = 1'b0;
    #1;
    checks++; if (PCSrcD !== 2'b00) begin errors++; $display("FAIL release_ops_pcsrc got=%b exp=00", PCSrcD); end
    RD2D = 32'd1;
    #1;
    checks++; if (PCSrcD !== 2'b01) begin errors++; $display("FAIL release_pcsrc got=%b exp=01", PCSrcD); end
    checks++; if (PCBranchD !== 32'h0000_0310) begin errors++; $display("FAIL release_target got=%h exp=00000310", PCBranchD); end
    tick();
    checks++; if (PCSrcD !== 2'b00 || ValidD !== 1'b0) begin errors++; $display("FAIL release_bubble got pcsrc=%b valid=%0b exp pcsrc=00 valid=0", PCSrcD, ValidD); end
    checks++; if (TakenCount !== 4'h4) begin errors++; $display("FAIL release_count got=%h exp=4", TakenCount); end
  endtask

  task automatic test_saturation;
    logic [3:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      InstrF = 32'h0800_0010; PCPlus4F = 32'h0000_1000 + 32'(i * 8);
      tick();
      checks++; if (PCSrcD !== 2'b10) begin errors++; $display("FAIL sat_pcsrc jump=%0d got=%b exp=10", i + 1, PCSrcD); end
      InstrF = 32'h2005_0005;
      tick();
      exp_cnt = (i + 1 >= 15) ? 4'hF : 4'(i + 1);
      checks++; if (TakenCount !== exp_cnt) begin errors++; $display("FAIL sat_count jump=%0d got=%h exp=%h", i + 1, TakenCount, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_wrap();
    test_jal();
    test_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
